// File: rtl/operand_scan_display_pkg.sv
// Shared types, segment codes and helpers for the operand scan display.
//   state_t     : sequencing states of the conversion FSM
//   SEG_*       : active-low {g,f,e,d,c,b,a} segment patterns
//   seg_decode  : BCD nibble to segment pattern, with forced blank
//   clog2       : ceiling log2, never below 1 so it can size a vector
package operand_scan_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    CONV  = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble, input logic blank);
    logic [6:0] s;
    s = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    s = SEG_0;
        4'd1:    s = SEG_1;
        4'd2:    s = SEG_2;
        4'd3:    s = SEG_3;
        4'd4:    s = SEG_4;
        4'd5:    s = SEG_5;
        4'd6:    s = SEG_6;
        4'd7:    s = SEG_7;
        4'd8:    s = SEG_8;
        4'd9:    s = SEG_9;
        default: s = SEG_BLANK;
      endcase
    end
    return s;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/operand_scan_display_signed_bcd_converter.sv
// Sequential signed-to-BCD converter (abs value + double dabble).
//   clk, reset_n : clock, async active-low reset
//   start        : one-cycle pulse; captures sign and magnitude of operand
//   operand      : two's-complement input
//   done_c       : high during the final shift cycle (combinational)
//   sign, bcd    : result; bcd is valid the cycle after done_c
module signed_bcd_converter
  import operand_scan_display_pkg::*;
#(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned BCD_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        operand,
  output logic                    done_c,
  output logic                    sign,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = clog2(WIDTH);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mag;
  logic [BCD_W-1:0] adj;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  assign done_c = active && (cnt == CNT_W'(WIDTH - 1));

  // Magnitude is kept unsigned so the most negative operand negates exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
      mag    <= '0;
      sign   <= 1'b0;
      bcd    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      sign   <= operand[WIDTH-1];
      mag    <= operand[WIDTH-1] ? (~operand + WIDTH'(1)) : operand;
      bcd    <= '0;
    end else if (active) begin
      bcd    <= {adj[BCD_W-2:0], mag[WIDTH-1]};
      mag    <= {mag[WIDTH-2:0], 1'b0};
      cnt    <= cnt + CNT_W'(1);
      if (done_c) active <= 1'b0;
    end
  end

endmodule

// File: rtl/operand_scan_display.sv
// Multi-channel signed operand display: captures operands on load, converts
// each to sign + BCD through one shared converter, and scans the result onto
// a common-anode multiplexed 7-segment bank.
//   clk, reset_n : clock, async active-low reset
//   load         : capture strobe, ignored while busy
//   operands     : channel k at operands[k*WIDTH +: WIDTH]
//   busy         : conversion in progress
//   seg          : active-low {g,f,e,d,c,b,a}
//   an           : active-low one-hot anode enables
module operand_scan_display
  import operand_scan_display_pkg::*;
#(
  parameter  int unsigned WIDTH         = 5,
  parameter  int unsigned CHANNELS      = 2,
  parameter  int unsigned BCD_DIGITS    = 2,
  parameter  int unsigned BLANK_LEADING = 1,
  parameter  int unsigned REFRESH_DIV   = 50000,
  localparam int unsigned NUM_DIGITS    = CHANNELS * (BCD_DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] operands,
  output logic                      busy,
  output logic [6:0]                seg,
  output logic [NUM_DIGITS-1:0]     an
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CH_W  = clog2(CHANNELS);
  localparam int unsigned IDX_W = clog2(NUM_DIGITS);
  localparam int unsigned PRE_W = clog2(REFRESH_DIV);

  state_t                    state, next_state;
  logic                      capture, conv_start, store_en, last_chan;
  logic [CHANNELS*WIDTH-1:0] shadow;
  logic [CH_W-1:0]           chan;
  logic                      conv_done, conv_sign;
  logic [BCD_W-1:0]          conv_bcd;
  logic                      pend_sign [CHANNELS];
  logic [BCD_W-1:0]          pend_bcd  [CHANNELS];
  logic                      nxt_sign  [CHANNELS];
  logic [BCD_W-1:0]          nxt_bcd   [CHANNELS];
  logic                      disp_sign [CHANNELS];
  logic [BCD_W-1:0]          disp_bcd  [CHANNELS];
  logic                      disp_valid;
  logic [PRE_W-1:0]          presc;
  logic [IDX_W-1:0]          idx;
  logic [6:0]                digit_seg [NUM_DIGITS];
  logic [3:0]                nib;
  logic                      above_zero;

  assign last_chan = (chan == CH_W'(CHANNELS - 1));

  signed_bcd_converter #(.WIDTH(WIDTH), .BCD_DIGITS(BCD_DIGITS)) u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .operand (shadow[chan*WIDTH +: WIDTH]),
    .done_c  (conv_done),
    .sign    (conv_sign),
    .bcd     (conv_bcd)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load) next_state = ABS;
      ABS:     next_state = CONV;
      CONV:    if (conv_done) next_state = STORE;
      STORE:   next_state = last_chan ? IDLE : ABS;
      default: next_state = IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    capture    = 1'b0;
    conv_start = 1'b0;
    store_en   = 1'b0;
    case (state)
      IDLE:    capture    = load;
      ABS:     conv_start = 1'b1;
      STORE:   store_en   = 1'b1;
      default: ;
    endcase
  end

  // Pending buffer with the current converter result merged into slot chan
  always_comb begin
    nxt_sign       = pend_sign;
    nxt_bcd        = pend_bcd;
    nxt_sign[chan] = conv_sign;
    nxt_bcd[chan]  = conv_bcd;
  end

  // Operand shadow, channel counter, pending and display buffers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      shadow     <= '0;
      chan       <= '0;
      disp_valid <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        pend_sign[k] <= 1'b0;
        pend_bcd[k]  <= '0;
        disp_sign[k] <= 1'b0;
        disp_bcd[k]  <= '0;
      end
    end else begin
      busy <= (next_state != IDLE);
      if (capture) begin
        shadow <= operands;
        chan   <= '0;
      end
      if (store_en) begin
        pend_sign <= nxt_sign;
        pend_bcd  <= nxt_bcd;
        if (last_chan) begin
          disp_sign  <= nxt_sign;
          disp_bcd   <= nxt_bcd;
          disp_valid <= 1'b1;
        end else begin
          chan <= chan + CH_W'(1);
        end
      end
    end
  end

  // Segment pattern for every digit position, walking each channel from its
  // most significant digit down so leading zeros can be suppressed.
  always_comb begin
    nib        = '0;
    above_zero = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) digit_seg[d] = SEG_BLANK;
    for (int k = 0; k < CHANNELS; k++) begin
      above_zero = 1'b1;
      for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
        nib = disp_bcd[k][i*4 +: 4];
        digit_seg[k*(BCD_DIGITS+1) + i] =
          seg_decode(nib, !disp_valid ||
                          ((BLANK_LEADING != 0) && (i != 0) && above_zero && (nib == 4'd0)));
        if (nib != 4'd0) above_zero = 1'b0;
      end
      digit_seg[k*(BCD_DIGITS+1) + BCD_DIGITS] =
        (disp_valid && disp_sign[k]) ? SEG_DASH : SEG_BLANK;
    end
  end

  // Free-running refresh scanner; seg/an trail the digit index by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      idx   <= '0;
      seg   <= SEG_BLANK;
      an    <= '1;
    end else begin
      if (presc == PRE_W'(REFRESH_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        presc <= presc + PRE_W'(1);
      end
      seg <= digit_seg[idx];
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_operand_scan_display.sv
// Self-checking bench for operand_scan_display: a default-width two-channel
// instance and an 8-bit single-channel instance, both with a fast refresh.
module tb_operand_scan_display;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_a, load_b;
  logic [9:0] ops_a;
  logic [7:0] ops_b;
  logic       busy_a, busy_b;
  logic [6:0] seg_a, seg_b;
  logic [5:0] an_a;
  logic [3:0] an_b;
  bit         use_b;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_seg [8];
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  always #5 clk = ~clk;

  operand_scan_display #(.REFRESH_DIV(DIV)) dut_a (
    .clk(clk), .reset_n(reset_n), .load(load_a), .operands(ops_a),
    .busy(busy_a), .seg(seg_a), .an(an_a)
  );

  operand_scan_display #(.WIDTH(8), .CHANNELS(1), .BCD_DIGITS(3), .REFRESH_DIV(DIV)) dut_b (
    .clk(clk), .reset_n(reset_n), .load(load_b), .operands(ops_b),
    .busy(busy_b), .seg(seg_b), .an(an_b)
  );

  wire       busy_m = use_b ? busy_b : busy_a;
  wire [6:0] seg_m  = use_b ? seg_b : seg_a;
  wire [7:0] an_m   = use_b ? {4'hF, an_b} : {2'b11, an_a};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit b, input logic [31:0] ops, input logic ld);
    if (b) begin ops_b = ops[7:0]; load_b = ld; end
    else   begin ops_a = ops[9:0]; load_a = ld; end
  endtask

  task automatic set_load(input bit b, input logic ld);
    if (b) load_b = ld;
    else   load_a = ld;
  endtask

  // Decimal reference: sign digit, magnitude digits, leading zeros blanked.
  task automatic build_expected(input int w, input int ch, input int bd, input logic [31:0] ops);
    int raw, val, m, ndig, tmp, pw;
    for (int d = 0; d < 8; d++) exp_seg[d] = BLANK;
    for (int k = 0; k < ch; k++) begin
      raw  = int'((ops >> (k*w)) & ((32'd1 << w) - 1));
      val  = (raw >= (1 << (w-1))) ? raw - (1 << w) : raw;
      m    = (val < 0) ? -val : val;
      ndig = 1;
      tmp  = m;
      while (tmp >= 10) begin tmp = tmp / 10; ndig++; end
      for (int i = 0; i < bd; i++) begin
        pw = 1;
        for (int j = 0; j < i; j++) pw = pw * 10;
        exp_seg[k*(bd+1) + i] = (i < ndig) ? seg_tab[(m / pw) % 10] : BLANK;
      end
      exp_seg[k*(bd+1) + bd] = (val < 0) ? DASH : BLANK;
    end
  endtask

  // Watch a full scan frame and compare every lit digit against exp_seg.
  task automatic check_frame(input int nd, input string tag);
    logic [7:0] a, seen;
    int zeros, idx;
    seen = '0;
    @(negedge clk);
    for (int t = 0; t < nd*DIV + DIV; t++) begin
      @(negedge clk);
      a = an_m; zeros = 0; idx = 0;
      for (int d = 0; d < nd; d++) if (a[d] == 1'b0) begin zeros++; idx = d; end
      chk({tag, "_an_onehot"}, zeros, 1);
      chk({tag, "_seg"}, {25'd0, seg_m}, {25'd0, exp_seg[idx]});
      seen[idx] = 1'b1;
    end
    chk({tag, "_all_digits"}, seen, (32'd1 << nd) - 1);
  endtask

  // Load, count busy cycles (optionally re-strobing load mid-conversion), check display.
  task automatic run_load(input bit b, input logic [31:0] ops, input int r1, input int r2,
                          input string tag);
    int n, w, ch, bd;
    use_b = b;
    w = b ? 8 : 5; ch = b ? 1 : 2; bd = b ? 3 : 2;
    @(negedge clk);
    set_in(b, ops, 1'b1);
    @(negedge clk);
    set_load(b, 1'b0);
    n = 0;
    for (int t = 0; t < 100; t++) begin
      if (busy_m !== 1'b1) break;
      n++;
      if (n == r1 || n == r2) set_in(b, ~ops, 1'b1);
      else                    set_load(b, 1'b0);
      @(negedge clk);
    end
    set_load(b, 1'b0);
    chk({tag, "_busy_cycles"}, n, ch*(w+2));
    build_expected(w, ch, bd, ops);
    check_frame(ch*(bd+1), tag);
  endtask

  initial begin
    logic [5:0] exp_an;
    reset_n = 1'b0; load_a = 1'b0; load_b = 1'b0; ops_a = '0; ops_b = '0; use_b = 1'b0;

    // Reset state, then the anode walk with a blank buffer
    repeat (3) @(negedge clk);
    chk("rst_seg_a", seg_a, 7'h7F);
    chk("rst_an_a", an_a, 6'h3F);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_seg_b", seg_b, 7'h7F);
    chk("rst_an_b", an_b, 4'hF);
    chk("rst_busy_b", busy_b, 1'b0);
    reset_n = 1'b1;
    for (int j = 1; j <= 2*6*DIV; j++) begin
      @(negedge clk);
      exp_an = ~(6'b000001 << (((j-1) / DIV) % 6));
      chk("walk_an", an_a, exp_an);
      chk("walk_seg", seg_a, 7'h7F);
    end

    // Directed operands
    run_load(1'b0, {22'd0, 5'b10110, 5'b00111}, 0, 0, "neg10_pos7");
    run_load(1'b0, {22'd0, 5'b10000, 5'b00000}, 0, 0, "neg16_zero");
    run_load(1'b0, {22'd0, 5'b01111, 5'b11111}, 3, 14, "load_ignored");

    // Reset in the middle of a conversion
    use_b = 1'b0;
    @(negedge clk);
    set_in(1'b0, {22'd0, 5'b00011, 5'b10101}, 1'b1);
    @(negedge clk);
    set_load(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("midconv_busy", busy_a, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_seg", seg_a, 7'h7F);
    chk("midrst_an", an_a, 6'h3F);
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < 8; d++) exp_seg[d] = BLANK;
    check_frame(6, "after_rst_blank");
    run_load(1'b0, {22'd0, 5'b00101, 5'b10001}, 0, 0, "after_rst_load");

    // Wide single-channel instance
    run_load(1'b1, 32'h80, 0, 0, "b_neg128");
    run_load(1'b1, 32'h7F, 0, 0, "b_pos127");
    run_load(1'b1, 32'h00, 0, 0, "b_zero");

    // Random operands on both instances
    for (int r = 0; r < 16; r++) begin
      run_load(($urandom_range(0, 3) == 0), $urandom, 0, 0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_scan_display.md
Name: operand_scan_display

Overview:
Parametrised successor to the two-operand 7-segment display stage of the ALU lab.
- Captures CHANNELS signed two's-complement operands on a load strobe.
- Converts each operand to sign + BCD magnitude with a sequential double-dabble converter.
- Drives one time-multiplexed common-anode 7-segment bank instead of one static display per digit.
- Sits between the operand switches / ALU result and the board display pins.

Parameters:
- WIDTH, 5: bits per operand, two's complement.
- CHANNELS, 2: operands displayed; channel 0 occupies the rightmost digits.
- BCD_DIGITS, 2: magnitude digits per channel; must hold 2^(WIDTH-1).
- BLANK_LEADING, 1: 1 = blank leading zeros above the ones digit.
- REFRESH_DIV, 50000: clk cycles each digit stays lit.
- NUM_DIGITS, derived: CHANNELS*(BCD_DIGITS+1), total anodes.

Ports:
- clk, in, 1: single clock; everything is rising-edge.
- reset_n, in, 1: asynchronous, active-low reset.
- load, in, 1: capture strobe, sampled while busy=0.
- operands, in, CHANNELS*WIDTH: channel k = operands[k*WIDTH +: WIDTH].
- busy, out, 1: conversion in progress.
- seg, out, 7: {g,f,e,d,c,b,a}, active-low.
- an, out, NUM_DIGITS: anode enables, active-low, one-hot-zero.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - seg=7'h7F, an=all ones, busy=0.
  - Display buffer = all blank; prescaler, digit index and FSM cleared.
  - Reset mid-conversion aborts the conversion; no partial result is ever shown.
- FSM states: IDLE, ABS, CONV, STORE.
  - IDLE: load=1 captures operands into a shadow register, sets channel c=0 and goes to ABS. busy=1 from the next cycle.
  - ABS (1 cycle): sign = msb; mag = sign ? -x : x, held as a WIDTH-bit unsigned value, so -2^(WIDTH-1) is exact. BCD register cleared.
  - CONV (WIDTH cycles): each cycle, add 3 to every BCD nibble >=5, then shift {bcd,mag} left one bit.
  - STORE (1 cycle): write sign and BCD into the pending buffer slot for c. If c==CHANNELS-1, copy pending to the display buffer atomically and go to IDLE; otherwise c++ and go to ABS.
- Latency: CHANNELS*(WIDTH+2) busy cycles (14 at defaults). busy falls the cycle after the final STORE.
- load while busy=1 is ignored, not queued. This includes load in the STORE cycle.
- Digit layout per channel k, base position p=k*(BCD_DIGITS+1):
  - p+i for i<BCD_DIGITS: BCD digit i, ones at p.
  - p+BCD_DIGITS: sign digit.
- Sign digit shows '-' (7'b0111111) when negative, blank when zero or positive.
- With BLANK_LEADING=1, BCD digits above the most significant nonzero digit are blank. The ones digit is always shown, so 0 displays as '0'.
- Scan:
  - Prescaler runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances and wraps NUM_DIGITS-1 to 0.
  - seg and an are registered and update 1 cycle after the index changes; an=~(1<<idx).
  - The first cycle after reset release drives idx 0.
- Segment codes (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - Segment code constants, including DASH and BLANK.
  - Function seg_decode(nibble, blank) for BCD-to-segment.
  - clog2 helper used for index and prescaler widths.
- One sub-module: signed_bcd_converter. It implements ABS/CONV for one operand with start/done handshake. The top instantiates it once and time-shares it across channels; the top keeps the channel counter, buffers and scanner.

Test Plan:
1. Reset held, then released (REFRESH_DIV=4):
   - During reset: seg=7F, an=all ones, busy=0.
   - After release: an walks 111110, 111101, ... every 4 cycles with seg=7F throughout.
2. Defaults, load with operands={5'b10110 (-10), 5'b00111 (7)}:
   - busy high exactly 14 cycles.
   - Digits 0..5 then read 1111000, 1111111, 1111111, 1000000, 1111001, 0111111 (shows "-10" and "7").
3. operands={5'b10000 (-16), 5'b00000 (0)}:
   - Digits 0..5 read 1000000, 1111111, 1111111, 0000010, 1111001, 0111111.
4. load re-asserted at cycles 3 and 14 of a conversion with different operands:
   - Both strobes ignored; the display shows the first operands; busy returns to 0 at cycle 15.
5. reset_n pulsed low at cycle 5 of a conversion:
   - busy=0 and the display goes all blank immediately; a later load converts normally.
6. WIDTH=8, BCD_DIGITS=3, CHANNELS=1, load 8'h80:
   - busy 10 cycles; digits 0..3 read 0000000, 0100100, 1111001, 0111111 (shows "-128").
